// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared bank of enable-gated registers.
// Grants one requester at a time, pulses one register enable, and exposes the bank contents.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*AW-1:0]     addr,
  input  logic [NREQ*WIDTH-1:0]  wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [DEPTH-1:0]       en,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_win;
  logic [PW-1:0]      w_win;
  logic               w_found;
  logic [AW-1:0]      r_addr;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_bank [DEPTH];

  // Round-robin search starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % NREQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    gnt    = '0;
    en     = '0;
    busy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_next = GRANT;
      end
      GRANT: begin
        w_next = IDLE;
        gnt    = NREQ'(1) << r_win;
        en     = DEPTH'(1) << r_addr;
        busy   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Decision is latched at the grant edge so later input changes cannot alter the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_ptr  <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_win  <= w_win;
        r_addr <= addr[int'(w_win)*AW +: AW];
        r_data <= wdata[int'(w_win)*WIDTH +: WIDTH];
      end
    end else begin
      r_ptr <= (int'(r_win) == NREQ - 1) ? '0 : r_win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) r_bank[k] <= '0;
    end else if (r_state == GRANT) begin
      r_bank[r_addr] <= r_data;
    end
  end

  always_comb begin
    q = '0;
    for (int k = 0; k < DEPTH; k++) q[k*WIDTH +: WIDTH] = r_bank[k];
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomized and directed bench for dff_bank_arbiter against a transaction-level bank model.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  en;
  logic [31:0] q;
  logic        busy;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.NREQ(4), .DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt), .en(en), .q(q), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester-side view of the handshake
  bit         p_req  [4];
  logic [1:0] p_addr [4];
  logic [7:0] p_data [4];

  // Reference model: pending transaction plus bank contents
  int         m_ptr;
  bit         m_pend;
  int         m_w;
  int         m_a;
  logic [7:0] m_d;
  logic [7:0] m_bank [4];

  int ord[$];

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]           = p_req[i];
      addr[i*2 +: 2]   = p_addr[i];
      wdata[i*8 +: 8]  = p_data[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      p_req[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
    end
    drive();
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    p_req[i] = 1'b1; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pend = 1'b0; m_w = 0; m_a = 0; m_d = '0;
    for (int k = 0; k < 4; k++) m_bank[k] = '0;
  endtask

  task automatic model_step();
    if (!reset) return;
    if (m_pend) begin
      m_bank[m_a] = m_d;
      m_ptr  = (m_w + 1) % 4;
      m_pend = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (p_req[c]) begin
          m_w = c; m_a = p_addr[c]; m_d = p_data[c]; m_pend = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic check_outs();
    logic [3:0]  eg;
    logic [3:0]  ee;
    logic [31:0] eq;
    eg = m_pend ? (4'b0001 << m_w) : 4'b0000;
    ee = m_pend ? (4'b0001 << m_a) : 4'b0000;
    eq = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    chk("gnt", gnt, eg);
    chk("en", en, ee);
    chk("busy", busy, m_pend);
    chk("q", q, eq);
  endtask

  task automatic record_grant();
    for (int i = 0; i < 4; i++) if (gnt[i]) ord.push_back(i);
  endtask

  task automatic cycle(input bit rnd);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
    record_grant();
    if (m_pend) p_req[m_w] = 1'b0;
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        if (!p_req[i] && !(m_pend && m_w == i) && $urandom_range(0, 2) == 0)
          set_req(i, 2'($urandom), 8'($urandom));
      end
    end
    drive();
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
    model_reset();

    // Reset held with random requests: all outputs must stay zero
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) set_req(i, 2'($urandom), 8'($urandom));
      for (int i = 0; i < 4; i++) p_req[i] = 1'($urandom);
      drive();
      cycle(1'b0);
    end
    clear_reqs();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) cycle(1'b0);

    // Single write
    set_req(2, 2'd3, 8'hA5);
    drive();
    cycle(1'b0);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_en", en, 4'b1000);
    cycle(1'b0);
    chk("single_q", q, 32'hA500_0000);

    // Return pointer to 0
    reset = 1'b0;
    model_reset();
    clear_reqs();
    #1;
    chk("rst_q", q, 32'h0);
    cycle(1'b0);
    reset = 1'b1;

    // Simultaneous requests, distinct addresses
    set_req(0, 2'd0, 8'hE1);
    set_req(1, 2'd1, 8'h96);
    set_req(2, 2'd2, 8'h5A);
    set_req(3, 2'd3, 8'hC3);
    drive();
    ord.delete();
    for (int n = 0; n < 8; n++) cycle(1'b0);
    chk("sim_count", ord.size(), 4);
    for (int i = 0; i < 4 && i < ord.size(); i++) chk("sim_order", ord[i], i);
    chk("sim_q", q, 32'hC35A_96E1);

    // Rotation and wrap
    set_req(0, 2'd2, 8'h3C);
    set_req(3, 2'd1, 8'h4D);
    drive();
    ord.delete();
    for (int n = 0; n < 4; n++) cycle(1'b0);
    chk("rot_count", ord.size(), 2);
    if (ord.size() == 2) begin
      chk("rot_first", ord[0], 0);
      chk("rot_second", ord[1], 3);
    end

    // Collision with pointer at 1
    set_req(0, 2'd3, 8'h77);
    drive();
    for (int n = 0; n < 2; n++) cycle(1'b0);
    set_req(1, 2'd0, 8'h11);
    set_req(2, 2'd0, 8'h22);
    drive();
    for (int n = 0; n < 4; n++) cycle(1'b0);
    chk("coll_reg0", q[7:0], 8'h22);

    // Reset in the grant cycle
    set_req(1, 2'd1, 8'hFF);
    drive();
    cycle(1'b0);
    chk("mid_gnt_pre", gnt, 4'b0010);
    reset = 1'b0;
    #1;
    chk("mid_gnt", gnt, 4'b0000);
    chk("mid_en", en, 4'b0000);
    chk("mid_busy", busy, 1'b0);
    chk("mid_q", q, 32'h0);
    model_reset();
    clear_reqs();
    for (int n = 0; n < 2; n++) cycle(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h40 + i));
    drive();
    cycle(1'b0);
    chk("ptr_restart", gnt, 4'b0001);
    for (int n = 0; n < 8; n++) cycle(1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
